// File: rtl/fsm_stim_sequencer.sv
// fsm_stim_sequencer: programmable pulse-train driver and z response counter
// for single-input pattern-detector FSMs. On an accepted start it drives w with
// n_frames frames of 'period' cycles, w high for the first high_len cycles of
// each frame. It then holds w low for DRAIN_CYC cycles and pulses done.
// z events are counted in RUN and DRAIN. A start with an illegal configuration
// is rejected with a one-cycle err pulse.
// Optional build macro: FSM_SEQ_EDGE_COUNT_EN. When it is defined, z_count
// counts rising edges of z. When it is undefined, z_count counts cycles with z=1.
module fsm_stim_sequencer #(
    parameter int CNT_W     = 4,
    parameter int FRM_W     = 4,
    parameter int Z_W       = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_len,
    input  logic [FRM_W-1:0] n_frames,
    input  logic             z,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [Z_W-1:0]   z_count
);

    localparam int D_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic [D_W-1:0]   dcnt_q, dcnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hl_q, hl_d;
    logic [FRM_W-1:0] nf_q, nf_d;

    logic             w_d, busy_d, done_d, err_d;
    logic [Z_W-1:0]   zc_d;
    logic             cfg_ok, accept, reject, counting, zinc;

    // The configuration is checked on the live inputs. It only matters in IDLE.
    assign cfg_ok   = (period >= CNT_W'(2)) && (high_len < period) && (n_frames != '0);
    assign accept   = (state_q == S_IDLE) && start && cfg_ok;
    assign reject   = (state_q == S_IDLE) && start && !cfg_ok;
    assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);

`ifdef FSM_SEQ_EDGE_COUNT_EN
    logic zprev_q, zprev_d;
    assign zinc = z & ~zprev_q;

    // Previous-z history is cleared on an accepted start, so a z that is already
    // high in the first RUN cycle counts as one edge.
    always_comb begin
        zprev_d = zprev_q;
        if (accept)
            zprev_d = 1'b0;
        else if (counting)
            zprev_d = z;
    end

    // Register holding z from the previous sampled cycle.
    always_ff @(posedge clk) begin
        if (reset) zprev_q <= 1'b0;
        else       zprev_q <= zprev_d;
    end
`else
    assign zinc = z;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and sequencing counters. The configuration is latched only on accept.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        frame_d = frame_q;
        dcnt_d  = dcnt_q;
        per_d   = per_q;
        hl_d    = hl_q;
        nf_d    = nf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    per_d   = period;
                    hl_d    = high_len;
                    nf_d    = n_frames;
                    phase_d = '0;
                    frame_d = '0;
                end
            end
            S_RUN: begin
                if (phase_q == per_q - CNT_W'(1)) begin
                    phase_d = '0;
                    if (frame_q == nf_q - FRM_W'(1)) begin
                        state_d = S_DRAIN;
                        frame_d = '0;
                        dcnt_d  = '0;
                    end else begin
                        frame_d = frame_q + FRM_W'(1);
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (dcnt_q == D_W'(DRAIN_CYC - 1))
                    state_d = S_DONE;
                else
                    dcnt_d = dcnt_q + D_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values. They come from the next state, so the registered outputs
    // line up with the state they describe. The z counter saturates instead of wrapping.
    always_comb begin
        w_d    = (state_d == S_RUN) && (phase_d < hl_d);
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        err_d  = reject;
        zc_d   = z_count;
        if (accept)
            zc_d = '0;
        else if (counting && zinc && (z_count != {Z_W{1'b1}}))
            zc_d = z_count + Z_W'(1);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            frame_q <= '0;
            dcnt_q  <= '0;
            per_q   <= '0;
            hl_q    <= '0;
            nf_q    <= '0;
            w       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            z_count <= '0;
        end else begin
            phase_q <= phase_d;
            frame_q <= frame_d;
            dcnt_q  <= dcnt_d;
            per_q   <= per_d;
            hl_q    <= hl_d;
            nf_q    <= nf_d;
            w       <= w_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            z_count <= zc_d;
        end
    end

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Scoreboard bench for fsm_stim_sequencer. The stimulus side computes each run's
// expected w trace, busy length and z_count from the frame rules and queues them.
// The monitor pops an entry on every done/err pulse and compares.
module tb_fsm_stim_sequencer;

    localparam int CNT_W = 4;
    localparam int FRM_W = 4;
    localparam int Z_W   = 3;
    localparam int DRN   = 2;
    localparam int ZMAX  = (1 << Z_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] period = '0;
    logic [CNT_W-1:0] high_len = '0;
    logic [FRM_W-1:0] n_frames = '0;
    logic             z;
    logic             zdrv = 1'b0;
    logic             ztie = 1'b0;
    logic             w, busy, done, err;
    logic [Z_W-1:0]   z_count;

    assign z = ztie ? w : zdrv;

    fsm_stim_sequencer #(.CNT_W(CNT_W), .FRM_W(FRM_W), .Z_W(Z_W), .DRAIN_CYC(DRN)) dut (
        .clk(clk), .reset(reset), .start(start), .period(period), .high_len(high_len),
        .n_frames(n_frames), .z(z), .w(w), .busy(busy), .done(done), .err(err),
        .z_count(z_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        int         zc;
        int         len;
        bit [255:0] wt;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_zc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: sample on the falling edge and build up the busy window.
    bit [255:0] tr;
    int         bcnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!busy) check("w_low_when_idle", w, 0);
                if (busy) begin
                    if (bcnt < DRN + 256) begin
                        if (bcnt < 256) tr[bcnt] = w;
                    end
                    bcnt++;
                end
                if (done || err) begin
                    if (q.size() == 0) begin
                        check("unexpected_done_err", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("err_vs_done", err, e.is_err);
                        check("done_vs_err", done, !e.is_err);
                        check("z_count", z_count, e.zc);
                        check("busy_len", bcnt, e.is_err ? 0 : e.len + DRN);
                        n_chk++;
                        if (!e.is_err && tr != e.wt) begin
                            n_fail++;
                            $display("FAIL w_trace: got %h expected %h", tr, e.wt);
                        end
                    end
                end
                if (!busy) begin
                    bcnt = 0;
                    tr = '0;
                end
            end else begin
                bcnt = 0;
                tr = '0;
            end
        end
    end

    // One run. zmode 0: z tied to w, 1: z constant high, 2: random z.
    // poke: RUN cycle in which a start with a different config is driven (-1 = none).
    // rst: RUN cycle in which reset is asserted (-1 = none).
    task automatic do_run(input int p, input int hl, input int nf, input int zmode,
                          input int poke, input int rst);
        exp_t e;
        bit   zs[$];
        bit   legal;
        int   L, cnt, zi, wi, prev;
        legal = (p >= 2) && (hl < p) && (nf != 0);
        ztie = (zmode == 0);
        e.wt = '0;
        e.is_err = !legal;
        e.len = 0;
        e.zc = last_zc;
        L = legal ? p * nf : 0;
        if (legal) begin
            cnt = 0;
            prev = 0;
            for (int i = 0; i < L + DRN; i++) begin
                wi = (i < L) ? (((i % p) < hl) ? 1 : 0) : 0;
                if (i < L) e.wt[i] = wi[0];
                zi = (zmode == 0) ? wi : (zmode == 1) ? 1 : int'($urandom_range(0, 1));
                zs.push_back(zi[0]);
`ifdef FSM_SEQ_EDGE_COUNT_EN
                if (zi == 1 && prev == 0 && cnt < ZMAX) cnt++;
`else
                if (zi == 1 && cnt < ZMAX) cnt++;
`endif
                prev = zi;
            end
            e.zc = cnt;
            e.len = L;
        end
        q.push_back(e);
        if (rst < 0) last_zc = e.zc;

        @(negedge clk);
        start = 1'b1;
        period = CNT_W'(p);
        high_len = CNT_W'(hl);
        n_frames = FRM_W'(nf);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < L + DRN + 4; c++) begin
            zdrv = (c < zs.size()) ? zs[c] : 1'b0;
            if (c == poke) begin
                start = 1'b1;
                period = CNT_W'($urandom_range(2, 15));
                high_len = CNT_W'($urandom_range(0, 1));
                n_frames = FRM_W'($urandom_range(1, 15));
            end else begin
                start = 1'b0;
            end
            if (c == rst) reset = 1'b1;
            @(negedge clk);
            if (c == rst) begin
                check("rst_w", w, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_zcount", z_count, 0);
                reset = 1'b0;
                q.delete();
                last_zc = 0;
            end
        end
        start = 1'b0;
        zdrv = 1'b0;
        check("run_completed", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int p, hl, nf;
        repeat (2) @(negedge clk);
        check("reset_w", w, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_zcount", z_count, 0);
        reset = 1'b0;
        @(negedge clk);

        do_run(9, 3, 2, 0, -1, -1);    // nominal
        do_run(3, 3, 2, 0, -1, -1);    // high_len == period
        do_run(9, 3, 0, 0, -1, -1);    // n_frames == 0
        do_run(1, 0, 2, 0, -1, -1);    // period < 2
        do_run(15, 1, 1, 1, -1, -1);   // saturation
        do_run(9, 3, 2, 0, -1, 13);    // reset at frame 1, phase 4
        do_run(9, 3, 2, 0, 5, -1);     // start while busy
        do_run(4, 0, 3, 0, -1, -1);    // high_len 0
        do_run(2, 1, 1, 2, -1, -1);    // shortest legal run

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                p = $urandom_range(2, 15);
                hl = $urandom_range(0, p - 1);
                nf = $urandom_range(1, 6);
            end else begin
                p = $urandom_range(0, 15);
                hl = $urandom_range(0, 15);
                nf = $urandom_range(0, 15);
            end
            do_run(p, hl, nf, $urandom_range(0, 2), -1, -1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
